team_03_wb_master: RTL and testbench
====================================

// Module: team_03_wb_master
// PURPOSE
//  Wishbone classic master engine for team_03. Turns single-beat internal read/write
//  requests (valid/ready) into Wishbone cycles on the ADR_O..CYC_O/DAT_I/ACK_I master
//  port. Returns read data or a timeout error on a valid/ready response channel.
//  Sits inside team_03_WB, directly behind the master port that leaves the team wrapper
//  toward the Nebula arbiter.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles STB_O may wait for ACK_I before abort; 0 = never time out
// PORTS
//  clk_i      in   1   system clock (wb_clk_i)
//  rst_i      in   1   reset, synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   engine can accept a request (high only in IDLE)
//  req_we     in   1   1=write, 0=read
//  req_addr   in   32  byte address
//  req_wdata  in   32  write data
//  req_sel    in   4   byte lanes
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer takes response
//  rsp_rdata  out  32  read data; 0 for writes and errors
//  rsp_err    out  1   1 = transfer timed out
//  busy       out  1   state != IDLE
//  ADR_O      out  32  Wishbone address, word-aligned
//  DAT_O      out  32  Wishbone write data
//  SEL_O      out  4   Wishbone byte select
//  WE_O       out  1   Wishbone write enable
//  STB_O      out  1   Wishbone strobe
//  CYC_O      out  1   Wishbone cycle
//  DAT_I      in   32  Wishbone read data
//  ACK_I      in   1   Wishbone acknowledge
// BEHAVIOUR
//  - FSM IDLE -> BUS -> RESP -> IDLE. All bus/response outputs are registered.
//    req_ready = (state==IDLE); busy = (state!=IDLE).
//  - Reset (any cycle, including mid-transfer): next edge gives state=IDLE.
//    ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O=0, rsp_valid/rsp_err=0, rsp_rdata=0, timer=0.
//    An in-flight cycle is dropped and its response is discarded.
//  - IDLE: on req_valid&req_ready at edge N:
//    ADR_O={req_addr[31:2],2'b00}, DAT_O=req_wdata, WE_O=req_we.
//    SEL_O=req_sel, or 4'hF if req_sel==0. CYC_O=STB_O=1 from N+1. Goto BUS, timer=0.
//  - BUS: all O signals held stable. At the edge where ACK_I=1:
//    CYC_O/STB_O->0; rsp_rdata = WE_O ? 0 : DAT_I; rsp_err=0; rsp_valid=1; goto RESP.
//    Otherwise timer++. If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with no ACK:
//    drop CYC_O/STB_O, rsp_rdata=0, rsp_err=1, rsp_valid=1, goto RESP.
//    ACK on the timeout cycle wins: the response is normal.
//  - Latency: ACK_I seen in the first STB cycle -> rsp_valid 2 cycles after the accept
//    edge. One request is outstanding at most; no pipelined/burst cycles (CTI/BTE unused).
//  - RESP: rsp_* held until rsp_valid&rsp_ready; that edge clears rsp_valid and goes IDLE.
//    req_ready stays low in RESP. Back-to-back transfers therefore take >=3 cycles each.
//  - ACK_I outside BUS is ignored. DAT_I is sampled only on the ACK edge.
//  - Timer width $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
// STRUCTURE
//  - team_03_wbm_pkg holds:
//    - typedef enum logic [1:0] {WBM_IDLE, WBM_BUS, WBM_RESP} wbm_state_t
//    - localparam WBM_DEFAULT_TIMEOUT=255
//    - typedef struct packed {we, addr, wdata, sel} wbm_req_t, shared with requesters
//  - Single module; the timeout counter is inline. No sub-module.
// TESTING
//  1. Read: req addr=0x3000_0006, sel=0; ACK_I with DAT_I=0xCAFE_F00D one cycle after STB
//     -> ADR_O=0x3000_0004, SEL_O=F, WE_O=0; rsp_rdata=0xCAFE_F00D, err=0.
//  2. Write: addr=0x3000_0010, wdata=0x1234_5678, sel=4'b0011; ACK after 5 wait cycles
//     -> DAT_O/SEL_O stable for all 6 STB cycles; rsp_rdata=0, err=0.
//  3. Timeout: TIMEOUT_CYCLES=8, ACK_I never asserted
//     -> STB_O high exactly 8 cycles; rsp_err=1, rsp_rdata=0.
//     Repeat with ACK on the 8th cycle -> err=0.
//  4. Backpressure: hold rsp_ready=0 for 10 cycles after the response
//     -> rsp_* stable, req_ready=0, new req_valid not accepted; then one handshake -> IDLE.
//  5. Reset mid-BUS: rst_i high for 1 cycle while STB_O=1
//     -> next cycle CYC_O=STB_O=0, rsp_valid=0; late ACK_I ignored.
//  6. Stray ACK_I in IDLE/RESP -> no state change, rsp_rdata unchanged.

Source files
------------

// File: rtl/team_03_wbm_pkg.sv
// rtl/team_03_wbm_pkg.sv - shared types and helpers for the team_03 Wishbone master engine
//
// Purpose : state encoding, default timeout and the request record used by
//           requesters that feed team_03_wb_master.
// Contents: wbm_state_t, WBM_DEFAULT_TIMEOUT, wbm_req_t, wbm_align_addr, wbm_eff_sel

package team_03_wbm_pkg;

    typedef enum logic [1:0] {
        WBM_IDLE,
        WBM_BUS,
        WBM_RESP
    } wbm_state_t;

    localparam int unsigned WBM_DEFAULT_TIMEOUT = 255;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } wbm_req_t;

    // Wishbone addresses are word addresses on this port; byte offset is dropped.
    function automatic logic [31:0] wbm_align_addr(input logic [29:0] word_addr);
        return {word_addr, 2'b00};
    endfunction

    // An empty byte-lane mask means "whole word".
    function automatic logic [3:0] wbm_eff_sel(input logic [3:0] sel);
        return (sel == 4'h0) ? 4'hF : sel;
    endfunction

endpackage

// File: rtl/team_03_wb_master.sv
// rtl/team_03_wb_master.sv - single-beat Wishbone classic master engine
//
// Purpose : converts one internal read/write request at a time into a
//           Wishbone classic cycle and returns read data or a timeout error.
// Ports   : clk_i, rst_i (sync, active-high)
//           request  : req_valid/req_ready, req_we, req_addr, req_wdata, req_sel
//           response : rsp_valid/rsp_ready, rsp_rdata, rsp_err
//           status   : busy
//           Wishbone : ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O, DAT_I, ACK_I
// Param   : TIMEOUT_CYCLES - STB cycles to wait for ACK_I before abort, 0 = never

module team_03_wb_master
    import team_03_wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WBM_DEFAULT_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        busy,

    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    // A zero timeout still needs a one-bit timer so the design elaborates.
    localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? '0
                                         : TW'(TIMEOUT_CYCLES - 1);

    wbm_state_t    state;
    logic [TW-1:0] timer;
    wbm_req_t      req;
    logic          timeout_hit;

    assign req = '{we: req_we, addr: req_addr, wdata: req_wdata, sel: req_sel};

    // Byte offset bits never reach the bus.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, req.addr[1:0]};

    assign req_ready = (state == WBM_IDLE);
    assign busy      = (state != WBM_IDLE);

    // Last permitted STB cycle without an ACK; ACK in that same cycle still wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= WBM_IDLE;
            timer     <= '0;
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            WE_O      <= 1'b0;
            STB_O     <= 1'b0;
            CYC_O     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                WBM_IDLE: begin
                    if (req_valid) begin
                        ADR_O <= wbm_align_addr(req.addr[31:2]);
                        DAT_O <= req.wdata;
                        SEL_O <= wbm_eff_sel(req.sel);
                        WE_O  <= req.we;
                        CYC_O <= 1'b1;
                        STB_O <= 1'b1;
                        timer <= '0;
                        state <= WBM_BUS;
                    end
                end

                WBM_BUS: begin
                    if (ACK_I) begin
                        CYC_O     <= 1'b0;
                        STB_O     <= 1'b0;
                        rsp_rdata <= WE_O ? 32'h0 : DAT_I;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= WBM_RESP;
                    end else if (timeout_hit) begin
                        CYC_O     <= 1'b0;
                        STB_O     <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= WBM_RESP;
                    end else if (timer != TIMER_MAX) begin
                        // Saturates so a disabled timeout cannot wrap into a false hit.
                        timer <= timer + 1'b1;
                    end
                end

                WBM_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= WBM_IDLE;
                    end
                end

                default: begin
                    state <= WBM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_team_03_wb_master.sv
// tb/tb_team_03_wb_master.sv - self-checking bench for team_03_wb_master

module tb_team_03_wb_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    int n_cmp  = 0;
    int n_fail = 0;

    team_03_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .ADR_O     (ADR_O),
        .DAT_O     (DAT_O),
        .SEL_O     (SEL_O),
        .WE_O      (WE_O),
        .STB_O     (STB_O),
        .CYC_O     (CYC_O),
        .DAT_I     (DAT_I),
        .ACK_I     (ACK_I)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: an engine is either idle, owning the bus for
    // some number of unacknowledged cycles, or holding a response.
    bit          m_ok = 0;
    bit          m_bus, m_resp;
    int          m_waited;
    logic [31:0] m_adr, m_dat, m_rdata;
    logic [3:0]  m_sel;
    logic        m_we, m_err;

    always @(posedge clk) begin
        if (rst_i) begin
            m_ok     <= 1;
            m_bus    <= 0;
            m_resp   <= 0;
            m_waited <= 0;
            m_adr    <= 0;
            m_dat    <= 0;
            m_sel    <= 0;
            m_we     <= 0;
            m_rdata  <= 0;
            m_err    <= 0;
        end else if (m_bus) begin
            if (ACK_I) begin
                m_bus   <= 0;
                m_resp  <= 1;
                m_rdata <= m_we ? 32'h0 : DAT_I;
                m_err   <= 0;
            end else if (m_waited + 1 == TO) begin
                m_bus   <= 0;
                m_resp  <= 1;
                m_rdata <= 32'h0;
                m_err   <= 1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (m_resp) begin
            if (rsp_ready) m_resp <= 0;
        end else if (req_valid) begin
            m_adr    <= req_addr & ~32'd3;
            m_dat    <= req_wdata;
            m_sel    <= (req_sel == 4'h0) ? 4'hF : req_sel;
            m_we     <= req_we;
            m_bus    <= 1;
            m_waited <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            cmp("cyc",       {31'b0, CYC_O},     {31'b0, m_bus});
            cmp("stb",       {31'b0, STB_O},     {31'b0, m_bus});
            cmp("req_ready", {31'b0, req_ready}, {31'b0, !m_bus && !m_resp});
            cmp("busy",      {31'b0, busy},      {31'b0, m_bus || m_resp});
            cmp("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_resp});
            cmp("rsp_rdata", rsp_rdata,          m_rdata);
            cmp("rsp_err",   {31'b0, rsp_err},   {31'b0, m_err});
            cmp("adr",       ADR_O,              m_adr);
            cmp("dat_o",     DAT_O,              m_dat);
            cmp("sel",       {28'b0, SEL_O},     {28'b0, m_sel});
            cmp("we",        {31'b0, WE_O},      {31'b0, m_we});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_sel   = sel;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        req_sel = 0; rsp_ready = 1; DAT_I = 0; ACK_I = 0;
        tick();
        tick();
        rst_i = 0;
        cmp("reset_busy",  {31'b0, busy},      32'd0);
        cmp("reset_ready", {31'b0, req_ready}, 32'd1);
        cmp("reset_adr",   ADR_O,              32'd0);

        // 1: read with ACK in first STB cycle, sel=0 -> all lanes
        issue(1'b0, 32'h3000_0006, 32'h0, 4'h0);
        cmp("t1_stb", {31'b0, STB_O}, 32'd1);
        cmp("t1_adr", ADR_O, 32'h3000_0004);
        cmp("t1_sel", {28'b0, SEL_O}, 32'hF);
        cmp("t1_we",  {31'b0, WE_O}, 32'd0);
        ACK_I = 1; DAT_I = 32'hCAFE_F00D;
        tick();
        ACK_I = 0; DAT_I = 0;
        cmp("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        cmp("t1_rdata", rsp_rdata, 32'hCAFE_F00D);
        cmp("t1_err", {31'b0, rsp_err}, 32'd0);
        tick();
        cmp("t1_idle", {31'b0, req_ready}, 32'd1);

        // 2: write, ACK after 5 wait cycles
        issue(1'b1, 32'h3000_0010, 32'h1234_5678, 4'b0011);
        for (int i = 0; i < 6; i++) begin
            cmp("t2_stb", {31'b0, STB_O}, 32'd1);
            cmp("t2_dat", DAT_O, 32'h1234_5678);
            cmp("t2_sel", {28'b0, SEL_O}, 32'h3);
            if (i == 5) begin
                ACK_I = 1; DAT_I = 32'hDEAD_BEEF;
            end
            tick();
        end
        ACK_I = 0;
        cmp("t2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        cmp("t2_rdata", rsp_rdata, 32'h0);
        cmp("t2_err", {31'b0, rsp_err}, 32'd0);
        tick();

        // 3a: timeout, no ACK at all
        issue(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!STB_O) break;
            n++;
            tick();
        end
        cmp("t3_stb_cycles", n, TO);
        cmp("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        cmp("t3_err", {31'b0, rsp_err}, 32'd1);
        cmp("t3_rdata", rsp_rdata, 32'h0);
        tick();

        // 3b: ACK on the final permitted cycle wins
        issue(1'b0, 32'h4000_0008, 32'h0, 4'hF);
        for (int i = 0; i < TO; i++) begin
            if (i == TO - 1) begin
                ACK_I = 1; DAT_I = 32'h0BAD_F00D;
            end
            tick();
        end
        ACK_I = 0;
        cmp("t3b_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        cmp("t3b_err", {31'b0, rsp_err}, 32'd0);
        cmp("t3b_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();

        // 4: response backpressure with a competing request
        rsp_ready = 0;
        issue(1'b0, 32'h5000_0000, 32'h0, 4'h1);
        ACK_I = 1; DAT_I = 32'hA5A5_5A5A;
        tick();
        ACK_I = 0;
        req_valid = 1; req_addr = 32'h6000_0000;
        for (int i = 0; i < 10; i++) begin
            cmp("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            cmp("t4_rdata", rsp_rdata, 32'hA5A5_5A5A);
            cmp("t4_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        cmp("t4_no_accept", {31'b0, STB_O}, 32'd0);
        rsp_ready = 1; req_valid = 0;
        tick();
        cmp("t4_done_valid", {31'b0, rsp_valid}, 32'd0);
        cmp("t4_done_ready", {31'b0, req_ready}, 32'd1);

        // 5: reset while STB is high, late ACK ignored
        issue(1'b0, 32'h7000_0000, 32'h0, 4'hF);
        tick();
        cmp("t5_stb_pre", {31'b0, STB_O}, 32'd1);
        rst_i = 1;
        tick();
        rst_i = 0;
        cmp("t5_cyc", {31'b0, CYC_O}, 32'd0);
        cmp("t5_stb", {31'b0, STB_O}, 32'd0);
        cmp("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        ACK_I = 1; DAT_I = 32'h5555_AAAA;
        tick();
        ACK_I = 0;
        cmp("t5_late_ack", {31'b0, rsp_valid}, 32'd0);
        cmp("t5_busy", {31'b0, busy}, 32'd0);

        // 6: stray ACK in IDLE, then in RESP
        ACK_I = 1; DAT_I = 32'hFFFF_FFFF;
        tick(); tick();
        ACK_I = 0;
        cmp("t6_idle_busy", {31'b0, busy}, 32'd0);
        cmp("t6_idle_rdata", rsp_rdata, 32'h0);
        rsp_ready = 0;
        issue(1'b0, 32'h8000_0000, 32'h0, 4'hF);
        ACK_I = 1; DAT_I = 32'h1111_2222;
        tick();
        DAT_I = 32'h3333_4444;
        tick(); tick();
        ACK_I = 0;
        cmp("t6_resp_rdata", rsp_rdata, 32'h1111_2222);
        cmp("t6_resp_valid", {31'b0, rsp_valid}, 32'd1);
        rsp_ready = 1;
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_i     = ($urandom_range(0, 199) == 0);
            req_valid = $urandom_range(0, 1);
            req_we    = $urandom_range(0, 1);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_sel   = 4'($urandom_range(0, 15));
            ACK_I     = ($urandom_range(0, 99) < 15);
            DAT_I     = $urandom;
            rsp_ready = ($urandom_range(0, 99) < 60);
            tick();
        end
        rst_i = 0; req_valid = 0; ACK_I = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
